// File: rtl/vga_pkg.sv
// Shared definitions for the VGA colour-depth reducer.
// Mode encodings, the 2x2 ordered-dither matrix and the default sync level.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_TRUNC  = 2'd0,
        MODE_ROUND  = 2'd1,
        MODE_DITHER = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    localparam logic SYNC_ACTIVE_DEFAULT = 1'b0;

    // Indexed [y parity][x parity]
    localparam logic [1:0] BAYER [2][2] = '{
        '{2'd0, 2'd2},
        '{2'd3, 2'd1}
    };

    function automatic logic [1:0] bayer(input logic y, input logic x);
        return BAYER[y][x];
    endfunction

endpackage

// File: rtl/color_quantize.sv
// One colour channel: offset add (stage 1), saturate and shift (stage 2).
// Saturation keys off the carry bit so full-scale sums never wrap to zero.
module color_quantize
    import vga_pkg::*;
#(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IN_BITS-1:0]  pix_in,
    input  logic [IN_BITS-1:0]  offset,
    output logic [OUT_BITS-1:0] pix_out
);

    localparam int D = IN_BITS - OUT_BITS;

    logic [IN_BITS:0]    sum_d;
    logic [IN_BITS:0]    sum_q;
    logic [IN_BITS:0]    shifted;
    logic [OUT_BITS-1:0] pix_d;
    logic [OUT_BITS-1:0] pix_q;
    logic                unused_shift;

    always_comb begin
        sum_d   = {1'b0, pix_in} + {1'b0, offset};
        shifted = sum_q >> D;
        pix_d   = sum_q[IN_BITS] ? '1 : shifted[OUT_BITS-1:0];
    end

    assign unused_shift = ^shifted[IN_BITS:OUT_BITS];

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
            pix_q <= '0;
        end else begin
            sum_q <= sum_d;
            pix_q <= pix_d;
        end
    end

    assign pix_out = pix_q;

endmodule

// File: rtl/vga_color_reducer.sv
// Reduces VGA colour depth by truncation, rounding or 2x2 ordered dither.
// Two-clock pipeline; syncs travel alongside the colour so they stay aligned.
module vga_color_reducer
    import vga_pkg::*;
#(
    parameter int   IN_BITS     = 8,
    parameter int   OUT_BITS    = 4,
    parameter logic SYNC_ACTIVE = SYNC_ACTIVE_DEFAULT
) (
    input  logic                CLK_25MHZ,
    input  logic                RESET,
    input  logic [1:0]          MODE,
    input  logic                VGA_HSYNC_IN,
    input  logic                VGA_VSYNC_IN,
    input  logic [IN_BITS-1:0]  VGA_RED_IN,
    input  logic [IN_BITS-1:0]  VGA_GREEN_IN,
    input  logic [IN_BITS-1:0]  VGA_BLUE_IN,
    output logic                VGA_HSYNC,
    output logic                VGA_VSYNC,
    output logic [OUT_BITS-1:0] VGA_RED,
    output logic [OUT_BITS-1:0] VGA_GREEN,
    output logic [OUT_BITS-1:0] VGA_BLUE
);

    localparam int D   = IN_BITS - OUT_BITS;
    localparam int RSH = (D > 0) ? D - 1 : 0;
    localparam int RND = (D > 0) ? (1 << RSH) : 0;
    localparam int DSH = (D >= 2) ? D - 2 : 0;

    logic  hs_act;
    logic  vs_act;

    logic  x_d, x_q;
    logic  y_d, y_q;
    logic  hs_prev_d, hs_prev_q;
    logic  vs_prev_d, vs_prev_q;
    mode_e mode_d, mode_q;
    logic  hs1_d, hs1_q;
    logic  vs1_d, vs1_q;
    logic  hs2_d, hs2_q;
    logic  vs2_d, vs2_q;

    logic [1:0]         bay;
    logic [IN_BITS-1:0] offset;

    assign hs_act = (VGA_HSYNC_IN == SYNC_ACTIVE);
    assign vs_act = (VGA_VSYNC_IN == SYNC_ACTIVE);

    always_comb begin
        x_d       = hs_act ? 1'b0 : ~x_q;
        y_d       = y_q;
        mode_d    = mode_q;
        hs_prev_d = hs_act;
        vs_prev_d = vs_act;
        hs1_d     = VGA_HSYNC_IN;
        vs1_d     = VGA_VSYNC_IN;
        hs2_d     = hs1_q;
        vs2_d     = vs1_q;
        if (vs_act) begin
            y_d = 1'b0;
        end else if (hs_act && !hs_prev_q) begin
            y_d = ~y_q;
        end
        // New mode only takes hold at the start of a frame
        if (vs_act && !vs_prev_q) begin
            mode_d = mode_e'(MODE);
        end
    end

    always_comb begin
        bay    = bayer(y_q, x_q);
        offset = '0;
        if (D > 0) begin
            unique case (mode_q)
                MODE_ROUND: offset = IN_BITS'(RND);
                MODE_DITHER: begin
                    if (D == 1) begin
                        offset = IN_BITS'(bay >> 1);
                    end else begin
                        offset = IN_BITS'(bay) << DSH;
                    end
                end
                default: offset = '0;
            endcase
        end
    end

    always_ff @(posedge CLK_25MHZ) begin
        if (RESET) begin
            x_q       <= 1'b0;
            y_q       <= 1'b0;
            hs_prev_q <= 1'b0;
            vs_prev_q <= 1'b0;
            mode_q    <= MODE_TRUNC;
            hs1_q     <= ~SYNC_ACTIVE;
            vs1_q     <= ~SYNC_ACTIVE;
            hs2_q     <= ~SYNC_ACTIVE;
            vs2_q     <= ~SYNC_ACTIVE;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            hs_prev_q <= hs_prev_d;
            vs_prev_q <= vs_prev_d;
            mode_q    <= mode_d;
            hs1_q     <= hs1_d;
            vs1_q     <= vs1_d;
            hs2_q     <= hs2_d;
            vs2_q     <= vs2_d;
        end
    end

    color_quantize #(
        .IN_BITS (IN_BITS),
        .OUT_BITS(OUT_BITS)
    ) u_red (
        .clk    (CLK_25MHZ),
        .rst    (RESET),
        .pix_in (VGA_RED_IN),
        .offset (offset),
        .pix_out(VGA_RED)
    );

    color_quantize #(
        .IN_BITS (IN_BITS),
        .OUT_BITS(OUT_BITS)
    ) u_green (
        .clk    (CLK_25MHZ),
        .rst    (RESET),
        .pix_in (VGA_GREEN_IN),
        .offset (offset),
        .pix_out(VGA_GREEN)
    );

    color_quantize #(
        .IN_BITS (IN_BITS),
        .OUT_BITS(OUT_BITS)
    ) u_blue (
        .clk    (CLK_25MHZ),
        .rst    (RESET),
        .pix_in (VGA_BLUE_IN),
        .offset (offset),
        .pix_out(VGA_BLUE)
    );

    assign VGA_HSYNC = hs2_q;
    assign VGA_VSYNC = vs2_q;

endmodule

// File: tb/tb_vga_color_reducer.sv
// Bench for vga_color_reducer: arithmetic reference model checked every
// cycle, plus literal expectations on directed video sequences.
module tb_vga_color_reducer;

    logic       clk = 1'b0;
    logic       RESET;
    logic [1:0] MODE;
    logic       HS_IN;
    logic       VS_IN;
    logic [7:0] R_IN;
    logic [7:0] G_IN;
    logic [7:0] B_IN;

    logic       VGA_HSYNC;
    logic       VGA_VSYNC;
    logic [3:0] VGA_RED;
    logic [3:0] VGA_GREEN;
    logic [3:0] VGA_BLUE;

    logic       w_hs;
    logic       w_vs;
    logic [7:0] w_red;
    logic [7:0] w_green;
    logic [7:0] w_blue;

    int checks   = 0;
    int failures = 0;

    always #20 clk = ~clk;

    vga_color_reducer u_dut (
        .CLK_25MHZ   (clk),
        .RESET       (RESET),
        .MODE        (MODE),
        .VGA_HSYNC_IN(HS_IN),
        .VGA_VSYNC_IN(VS_IN),
        .VGA_RED_IN  (R_IN),
        .VGA_GREEN_IN(G_IN),
        .VGA_BLUE_IN (B_IN),
        .VGA_HSYNC   (VGA_HSYNC),
        .VGA_VSYNC   (VGA_VSYNC),
        .VGA_RED     (VGA_RED),
        .VGA_GREEN   (VGA_GREEN),
        .VGA_BLUE    (VGA_BLUE)
    );

    vga_color_reducer #(
        .IN_BITS (8),
        .OUT_BITS(8)
    ) u_wide (
        .CLK_25MHZ   (clk),
        .RESET       (RESET),
        .MODE        (MODE),
        .VGA_HSYNC_IN(HS_IN),
        .VGA_VSYNC_IN(VS_IN),
        .VGA_RED_IN  (R_IN),
        .VGA_GREEN_IN(G_IN),
        .VGA_BLUE_IN (B_IN),
        .VGA_HSYNC   (w_hs),
        .VGA_VSYNC   (w_vs),
        .VGA_RED     (w_red),
        .VGA_GREEN   (w_green),
        .VGA_BLUE    (w_blue)
    );

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference arithmetic: (v + offset) / 2^d, clipped to the output range
    function automatic int reduce(input int v, input int mode,
                                  input int xp, input int yp,
                                  input int inb, input int outb);
        int bay [4];
        int d;
        int off;
        int r;
        int mx;
        bay = '{0, 2, 3, 1};
        d   = inb - outb;
        off = 0;
        if (d > 0) begin
            if (mode == 1) begin
                off = 2 ** (d - 1);
            end else if (mode == 2) begin
                if (d == 1) off = bay[yp * 2 + xp] / 2;
                else        off = bay[yp * 2 + xp] * (2 ** d) / 4;
            end
        end
        r  = (v + off) / (2 ** d);
        mx = (2 ** outb) - 1;
        if (r > mx) r = mx;
        return r;
    endfunction

    int  m_x, m_y, m_mode;
    bit  m_hsp, m_vsp;
    bit  live = 0;
    int  e1_r, e1_g, e1_b, e1_hs, e1_vs;
    int  e2_r, e2_g, e2_b, e2_hs, e2_vs;
    int  e1_wr, e1_wg, e1_wb;
    int  e2_wr, e2_wg, e2_wb;

    always @(posedge clk) begin
        bit hsa;
        bit vsa;
        if (RESET) begin
            {e1_r, e1_g, e1_b, e2_r, e2_g, e2_b} = '0;
            {e1_wr, e1_wg, e1_wb, e2_wr, e2_wg, e2_wb} = '0;
            e1_hs = 1; e1_vs = 1; e2_hs = 1; e2_vs = 1;
            m_x = 0; m_y = 0; m_mode = 0;
            m_hsp = 0; m_vsp = 0;
            live = 1;
        end else begin
            e2_r = e1_r; e2_g = e1_g; e2_b = e1_b;
            e2_wr = e1_wr; e2_wg = e1_wg; e2_wb = e1_wb;
            e2_hs = e1_hs; e2_vs = e1_vs;
            e1_r  = reduce(R_IN, m_mode, m_x, m_y, 8, 4);
            e1_g  = reduce(G_IN, m_mode, m_x, m_y, 8, 4);
            e1_b  = reduce(B_IN, m_mode, m_x, m_y, 8, 4);
            e1_wr = reduce(R_IN, m_mode, m_x, m_y, 8, 8);
            e1_wg = reduce(G_IN, m_mode, m_x, m_y, 8, 8);
            e1_wb = reduce(B_IN, m_mode, m_x, m_y, 8, 8);
            e1_hs = HS_IN;
            e1_vs = VS_IN;
            hsa = (HS_IN == 1'b0);
            vsa = (VS_IN == 1'b0);
            if (vsa && !m_vsp) m_mode = MODE;
            if (vsa) m_y = 0;
            else if (hsa && !m_hsp) m_y = 1 - m_y;
            m_x = hsa ? 0 : 1 - m_x;
            m_hsp = hsa;
            m_vsp = vsa;
        end
    end

    always @(negedge clk) begin
        if (live) begin
            chk("m_red",   VGA_RED,   e2_r);
            chk("m_green", VGA_GREEN, e2_g);
            chk("m_blue",  VGA_BLUE,  e2_b);
            chk("m_hs",    VGA_HSYNC, e2_hs);
            chk("m_vs",    VGA_VSYNC, e2_vs);
            chk("m_wred",  w_red,     e2_wr);
            chk("m_wgreen", w_green,  e2_wg);
            chk("m_wblue", w_blue,    e2_wb);
            chk("m_whs",   w_hs,      e2_hs);
        end
    end

    task automatic step(input logic hs, input logic vs,
                        input logic [7:0] r, input logic [7:0] g,
                        input logic [7:0] b);
        HS_IN = hs;
        VS_IN = vs;
        R_IN  = r;
        G_IN  = g;
        B_IN  = b;
        @(negedge clk);
    endtask

    task automatic vpulse();
        step(0, 0, 8'h00, 8'h00, 8'h00);
        step(0, 0, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic hpulse();
        step(0, 1, 8'h00, 8'h00, 8'h00);
        step(0, 1, 8'h00, 8'h00, 8'h00);
    endtask

    // Drives n pixels of 0x88; pixel k must come out as pat[k % 2]
    task automatic line88(input int n, input int p0, input int p1,
                          input string name);
        for (int i = 0; i <= n; i++) begin
            step(1, 1, 8'h88, 8'h88, 8'h88);
            if (i >= 1) begin
                chk(name, VGA_RED, ((i - 1) % 2 == 0) ? p0 : p1);
            end
        end
    endtask

    logic [7:0] tbl_r [8];
    logic [7:0] tbl_g [8];
    logic [7:0] tbl_b [8];

    initial begin
        tbl_r = '{8'h00, 8'hFF, 8'h07, 8'h08, 8'h7F, 8'h80, 8'hF7, 8'h3C};
        tbl_g = '{8'hFF, 8'h00, 8'h17, 8'hF0, 8'hF9, 8'h01, 8'h10, 8'hC3};
        tbl_b = '{8'h55, 8'hAA, 8'hEF, 8'hFE, 8'h0F, 8'h18, 8'h27, 8'h99};

        RESET = 1'b1;
        MODE  = 2'd0;
        HS_IN = 1'b1;
        VS_IN = 1'b1;
        R_IN  = 8'hFF;
        G_IN  = 8'hFF;
        B_IN  = 8'hFF;

        @(negedge clk);
        step(1, 1, 8'hFF, 8'hFF, 8'hFF);
        step(0, 0, 8'hFF, 8'hFF, 8'hFF);
        chk("rst_red", VGA_RED, 0);
        chk("rst_hs", VGA_HSYNC, 1);
        chk("rst_vs", VGA_VSYNC, 1);

        RESET = 1'b0;
        step(0, 1, 8'hAB, 8'h12, 8'h34);
        chk("lat_early_red", VGA_RED, 0);
        chk("lat_early_hs", VGA_HSYNC, 1);
        step(1, 1, 8'h00, 8'h00, 8'h00);
        chk("trunc_red", VGA_RED, 4'hA);
        chk("trunc_hs", VGA_HSYNC, 0);
        step(1, 1, 8'h00, 8'h00, 8'h00);

        MODE = 2'd1;
        vpulse();
        step(1, 1, 8'h98, 8'h17, 8'h80);
        step(1, 1, 8'hF8, 8'hFF, 8'h07);
        chk("round_red", VGA_RED, 4'hA);
        step(1, 1, 8'h00, 8'h00, 8'h00);
        chk("round_sat", VGA_RED, 4'hF);
        chk("round_sat_g", VGA_GREEN, 4'hF);

        for (int i = 0; i < 8; i++) begin
            step(1, 1, tbl_r[i], tbl_g[i], tbl_b[i]);
        end
        hpulse();

        MODE = 2'd2;
        vpulse();
        line88(8, 8, 9, "dith_even");
        hpulse();
        line88(8, 9, 8, "dith_odd");
        step(1, 1, 8'hFF, 8'hFF, 8'hFF);
        step(1, 1, 8'h00, 8'h00, 8'h00);
        chk("wide_ff", w_red, 8'hFF);
        chk("dith_sat", VGA_RED, 4'hF);
        for (int i = 0; i < 8; i++) begin
            step(1, 1, tbl_r[i], tbl_g[i], tbl_b[i]);
        end
        hpulse();

        MODE = 2'd0;
        vpulse();
        for (int i = 0; i <= 4; i++) begin
            if (i == 1) MODE = 2'd2;
            step(1, 1, 8'h88, 8'h88, 8'h88);
            if (i >= 1) chk("midframe_trunc", VGA_RED, 8);
        end
        hpulse();
        line88(4, 8, 8, "midframe_line2");
        vpulse();
        line88(4, 8, 9, "after_vsync_dith");

        step(1, 1, 8'h88, 8'h88, 8'h88);
        RESET = 1'b1;
        step(1, 1, 8'h88, 8'h88, 8'h88);
        chk("midrst_red", VGA_RED, 0);
        chk("midrst_grn", VGA_GREEN, 0);
        chk("midrst_blu", VGA_BLUE, 0);
        chk("midrst_hs", VGA_HSYNC, 1);
        chk("midrst_vs", VGA_VSYNC, 1);
        RESET = 1'b0;
        step(1, 1, 8'h88, 8'h88, 8'h88);
        chk("post_rst_flush", VGA_RED, 0);
        step(1, 1, 8'h99, 8'h88, 8'h88);
        chk("post_rst_trunc", VGA_RED, 8);
        step(1, 1, 8'h88, 8'h88, 8'h88);
        chk("post_rst_trunc2", VGA_RED, 9);
        hpulse();
        MODE = 2'd2;
        vpulse();
        line88(4, 8, 9, "post_rst_dith");

        MODE = 2'd3;
        vpulse();
        step(1, 1, 8'h9F, 8'h9F, 8'h9F);
        step(1, 1, 8'h00, 8'h00, 8'h00);
        chk("rsvd_trunc", VGA_RED, 9);
        step(1, 1, 8'h00, 8'h00, 8'h00);
        step(1, 1, 8'h00, 8'h00, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_color_reducer.md
VGA_COLOR_REDUCER -- requirements
Module: vga_color_reducer

Interface
REQ-001 Parameter IN_BITS, default 8: input colour depth per channel, 2..10.
REQ-002 Parameter OUT_BITS, default 4: output colour depth per channel, 1..IN_BITS.
REQ-003 Parameter SYNC_ACTIVE, default 1'b0: asserted level of HSYNC/VSYNC.
REQ-004 CLK_25MHZ  in  1  pixel clock; the single clock of the block.
REQ-005 RESET  in  1  synchronous, active-high reset.
REQ-006 MODE  in  2  reduction mode: 0 truncate, 1 round, 2 ordered dither, 3 reserved (treated as truncate).
REQ-007 VGA_HSYNC_IN  in  1  horizontal sync from the video generator.
REQ-008 VGA_VSYNC_IN  in  1  vertical sync from the video generator.
REQ-009 VGA_RED_IN, VGA_GREEN_IN, VGA_BLUE_IN  in  IN_BITS each  full-depth colour.
REQ-010 VGA_HSYNC, VGA_VSYNC  out  1 each  delayed syncs.
REQ-011 VGA_RED, VGA_GREEN, VGA_BLUE  out  OUT_BITS each  reduced colour.

Function
REQ-012 Fixed latency of 2 clocks from inputs to all outputs; syncs and colour leave aligned.
REQ-013 D = IN_BITS - OUT_BITS; when D = 0, colour passes unchanged with the 2-clock delay, regardless of MODE.
REQ-014 Truncate: output = input[IN_BITS-1:D].
REQ-015 Round: output = (input + 2^(D-1)) >> D, computed at IN_BITS+1 width, saturated to 2^OUT_BITS - 1.
REQ-016 Dither: output = (input + offset) >> D, saturated as in REQ-015; offset = B[y][x] * 2^D / 4 with Bayer table B = {{0,2},{3,1}}, index [y parity][x parity].
REQ-017 Dither with D = 1 uses offset = B[y][x] >> 1 (values 0,1,1,0).
REQ-018 x parity: cleared every clock VGA_HSYNC_IN is asserted; toggles every clock it is deasserted (first pixel after sync = even).
REQ-019 y parity: toggles on each HSYNC deasserted-to-asserted edge; cleared every clock VGA_VSYNC_IN is asserted.
REQ-020 MODE is captured into an internal mode register only on the VSYNC deasserted-to-asserted edge; mid-frame MODE changes have no effect until the next frame.
REQ-021 Stage 1 registers syncs, parities-selected offset and pre-shift sums; stage 2 registers shift/saturate results and syncs.
REQ-022 The same offset applies to all three channels in a given pixel.
REQ-023 Saturation: any sum exceeding 2^IN_BITS - 1 yields output all-ones; no wrap-around.

Reset
REQ-024 While RESET is high: colour outputs 0, VGA_HSYNC/VGA_VSYNC = ~SYNC_ACTIVE, both pipeline stages flushed to those values, x/y parity 0, mode register 0 (truncate).
REQ-025 RESET asserted mid-line takes effect at the next clock edge; the first valid output appears 2 clocks after RESET falls.

Structure
REQ-026 Shared package vga_pkg holds: mode encodings (MODE_TRUNC, MODE_ROUND, MODE_DITHER), the 2x2 Bayer table, sync-active default constant.
REQ-027 One sub-module, color_quantize (one channel: offset add, saturate, shift, register), instantiated three times; parity tracking, mode capture and sync pipeline live in the top.

Verification (IN_BITS=8, OUT_BITS=4, SYNC_ACTIVE=0)
REQ-028 MODE=0 from reset, RED_IN=0xAB -> VGA_RED=0xA exactly 2 clocks later, syncs delayed identically.
REQ-029 MODE=1 latched at a VSYNC edge, RED_IN=0x98 -> 0xA; RED_IN=0xF8 -> 0xF (saturated, not 0x0).
REQ-030 MODE=2, constant RED_IN=0x88 over two lines -> even line: 8,9,8,9...; odd line: 9,8,9,8...
REQ-031 MODE switched 0->2 mid-frame -> output stays truncated until the next VSYNC assertion edge, dithered afterwards.
REQ-032 RESET pulsed for 1 clock mid-line -> next clock all colour outputs 0, syncs high; valid data resumes 2 clocks after release with x parity restarting at the next HSYNC.
REQ-033 OUT_BITS=8 instance, MODE=2, RED_IN=0xFF -> VGA_RED=0xFF, no dither applied.
